transfer_egress_arbiter: RTL and testbench

Egress merger on the far side of the transfer layer. Drains the four per-port output FIFOs (P0–P3) and merges them into a single 12-bit stream. Arbitration is round-robin, with an optional almost-full priority override. Keeps a per-port forwarded-word counter that is readable through the same req/idx counter interface the transfer layer exposes.

---
 rtl/transfer_egress_arbiter_if.sv | 48 ++++
 rtl/transfer_egress_arbiter.sv | 147 ++++++++++++++
 tb/tb_transfer_egress_arbiter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/transfer_egress_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : transfer_egress_arbiter_if
// Purpose  : Bundles the port-FIFO side, the merged output stream and the
//            counter-read handshake of the egress arbiter.
// Ports    : slave  - arbiter view (FIFO flags/data, stall, init, req/idx in;
//                     pops, merged stream, counter read out)
//            master - environment view (mirror of slave)
// Revision : 1.0 - initial release
// ============================================================================
interface transfer_egress_arbiter_if #(
    parameter int DATA_WIDTH = 12,
    parameter int CNT_WIDTH  = 5
);
    logic                  init;
    logic                  emptyP0, emptyP1, emptyP2, emptyP3;
    logic                  almostFullP0, almostFullP1, almostFullP2, almostFullP3;
    logic [DATA_WIDTH-1:0] dataOutputP0, dataOutputP1, dataOutputP2, dataOutputP3;
    logic                  stall;
    logic                  req;
    logic [2:0]            idx;
    logic                  popOutP0, popOutP1, popOutP2, popOutP3;
    logic [DATA_WIDTH-1:0] dataOut;
    logic                  validOut;
    logic [CNT_WIDTH-1:0]  counterOut;
    logic                  counterValid;

    modport slave (
        input  init,
        input  emptyP0, emptyP1, emptyP2, emptyP3,
        input  almostFullP0, almostFullP1, almostFullP2, almostFullP3,
        input  dataOutputP0, dataOutputP1, dataOutputP2, dataOutputP3,
        input  stall, req, idx,
        output popOutP0, popOutP1, popOutP2, popOutP3,
        output dataOut, validOut, counterOut, counterValid
    );

    modport master (
        output init,
        output emptyP0, emptyP1, emptyP2, emptyP3,
        output almostFullP0, almostFullP1, almostFullP2, almostFullP3,
        output dataOutputP0, dataOutputP1, dataOutputP2, dataOutputP3,
        output stall, req, idx,
        input  popOutP0, popOutP1, popOutP2, popOutP3,
        input  dataOut, validOut, counterOut, counterValid
    );
endinterface
`default_nettype wire

// File: rtl/transfer_egress_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : transfer_egress_arbiter
// Purpose  : Merges four port FIFOs (P0..P3) into one stream using
//            round-robin arbitration, with per-port forwarded-word counters
//            readable through a req/idx interface (1-cycle latency).
// Ports    : clk   - rising-edge clock
//            reset - asynchronous active-high reset
//            bus   - transfer_egress_arbiter_if.slave (FIFO flags/data,
//                    stall, init, req/idx in; pops, dataOut/validOut,
//                    counterOut/counterValid out)
// Options  : TRANSFER_EGRESS_PRIORITY_EN - when defined, non-empty ports
//            flagging almost-full restrict the round-robin search to
//            themselves; otherwise almostFull inputs are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module transfer_egress_arbiter #(
    parameter int DATA_WIDTH = 12,
    parameter int CNT_WIDTH  = 5
) (
    input  wire logic             clk,
    input  wire logic             reset,
    transfer_egress_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INIT   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t                state_q;
    logic [1:0]            rr_ptr_q;
    logic [CNT_WIDTH-1:0]  cnt_q [4];
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  valid_out_q;
    logic [CNT_WIDTH-1:0]  cnt_out_q;
    logic                  cnt_valid_q;

    logic [3:0]            w_elig;
    logic [3:0]            w_cand;
    logic [3:0]            w_grant_vec;
    logic [1:0]            w_grant_idx;
    logic                  w_grant_any;
    logic [DATA_WIDTH-1:0] w_sel_data;

    assign w_elig = ~{bus.emptyP3, bus.emptyP2, bus.emptyP1, bus.emptyP0};

`ifdef TRANSFER_EGRESS_PRIORITY_EN
    logic [3:0] w_prio;
    assign w_prio = w_elig & {bus.almostFullP3, bus.almostFullP2,
                              bus.almostFullP1, bus.almostFullP0};
    // Almost-full ports, when any, are the only candidates for this grant.
    assign w_cand = (|w_prio) ? w_prio : w_elig;
`else
    assign w_cand = w_elig;
`endif

    // Round-robin search starting one past the last granted port. The pop
    // depends only on flags, stall, init, state and pointer - never on data.
    always_comb begin
        logic [1:0] v_probe;
        v_probe     = 2'd0;
        w_grant_vec = 4'b0000;
        w_grant_idx = rr_ptr_q;
        w_grant_any = 1'b0;
        if ((state_q == ST_ACTIVE) && !bus.stall && !bus.init) begin
            for (int k = 1; k <= 4; k++) begin
                v_probe = rr_ptr_q + 2'(k);
                if (!w_grant_any && w_cand[v_probe]) begin
                    w_grant_any = 1'b1;
                    w_grant_idx = v_probe;
                end
            end
            if (w_grant_any) begin
                w_grant_vec[w_grant_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        case (w_grant_idx)
            2'd0:    w_sel_data = bus.dataOutputP0;
            2'd1:    w_sel_data = bus.dataOutputP1;
            2'd2:    w_sel_data = bus.dataOutputP2;
            default: w_sel_data = bus.dataOutputP3;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= 2'd3;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            cnt_out_q   <= '0;
            cnt_valid_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            valid_out_q <= w_grant_any;
            if (w_grant_any) begin
                data_out_q         <= w_sel_data;
                rr_ptr_q           <= w_grant_idx;
                cnt_q[w_grant_idx] <= cnt_q[w_grant_idx] + CNT_WIDTH'(1);
            end

            // Read samples the pre-increment value when a pop hits the same port.
            if (bus.req) begin
                cnt_valid_q <= 1'b1;
                cnt_out_q   <= bus.idx[2] ? '0 : cnt_q[bus.idx[1:0]];
            end else begin
                cnt_valid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (bus.init) state_q <= ST_INIT;
                end
                ST_INIT: begin
                    // Pointer at 3 makes P0 the first port searched.
                    rr_ptr_q <= 2'd3;
                    for (int i = 0; i < 4; i++) begin
                        cnt_q[i] <= '0;
                    end
                    state_q <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (bus.init) state_q <= ST_INIT;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.popOutP0     = w_grant_vec[0];
    assign bus.popOutP1     = w_grant_vec[1];
    assign bus.popOutP2     = w_grant_vec[2];
    assign bus.popOutP3     = w_grant_vec[3];
    assign bus.dataOut      = data_out_q;
    assign bus.validOut     = valid_out_q;
    assign bus.counterOut   = cnt_out_q;
    assign bus.counterValid = cnt_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_transfer_egress_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_transfer_egress_arbiter
// Purpose  : Self-checking bench for transfer_egress_arbiter: directed
//            scenarios followed by randomized traffic, all compared against
//            a behavioural model of the arbitration and counter rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_transfer_egress_arbiter;
    localparam int DW = 12;
    localparam int CW = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    transfer_egress_arbiter_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    transfer_egress_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic          t_init, t_stall, t_req;
    logic [2:0]    t_idx;
    logic [3:0]    t_empty, t_afull;
    logic [DW-1:0] t_data [4];
    logic [3:0]    w_pop;

    assign bus.init         = t_init;
    assign bus.stall        = t_stall;
    assign bus.req          = t_req;
    assign bus.idx          = t_idx;
    assign bus.emptyP0      = t_empty[0];
    assign bus.emptyP1      = t_empty[1];
    assign bus.emptyP2      = t_empty[2];
    assign bus.emptyP3      = t_empty[3];
    assign bus.almostFullP0 = t_afull[0];
    assign bus.almostFullP1 = t_afull[1];
    assign bus.almostFullP2 = t_afull[2];
    assign bus.almostFullP3 = t_afull[3];
    assign bus.dataOutputP0 = t_data[0];
    assign bus.dataOutputP1 = t_data[1];
    assign bus.dataOutputP2 = t_data[2];
    assign bus.dataOutputP3 = t_data[3];
    assign w_pop = {bus.popOutP3, bus.popOutP2, bus.popOutP1, bus.popOutP0};

    // Reference model: phase 0 = idle, 1 = init, 2 = active.
    int m_phase, m_rr, m_cnt[4];
    int m_data, m_valid, m_co, m_cv;
    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_pick();
        logic [3:0] set;
        if (m_phase != 2 || t_stall || t_init) return -1;
        set = ~t_empty;
`ifdef TRANSFER_EGRESS_PRIORITY_EN
        if ((set & t_afull) != 4'b0000) set = set & t_afull;
`endif
        for (int k = 1; k <= 4; k++) begin
            if (set[(m_rr + k) % 4]) return (m_rr + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_rr = 3;
        m_data = 0; m_valid = 0; m_co = 0; m_cv = 0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    task automatic set_idle();
        t_init = 0; t_stall = 0; t_req = 0; t_idx = 0;
        t_empty = 4'hF; t_afull = 4'h0;
        for (int i = 0; i < 4; i++) t_data[i] = '0;
    endtask

    // Called at posedge+1 with inputs already applied; returns at posedge+1.
    task automatic cycle();
        int g;
        logic [3:0] exp_pop;
        #1;
        g = model_pick();
        exp_pop = 4'b0000;
        if (g >= 0) exp_pop[g] = 1'b1;
        chk("pop", w_pop, exp_pop);
        if (t_req) begin
            m_cv = 1;
            m_co = (t_idx < 3'd4) ? m_cnt[int'(t_idx[1:0])] : 0;
        end else begin
            m_cv = 0;
        end
        if (g >= 0) begin
            m_valid = 1; m_data = int'(t_data[g]);
            m_cnt[g] = (m_cnt[g] + 1) % 32; m_rr = g;
        end else begin
            m_valid = 0;
        end
        if (m_phase == 1) begin
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            m_rr = 3; m_phase = 2;
        end else if (t_init) begin
            m_phase = 1;
        end
        @(posedge clk);
        #1;
        chk("dataOut", bus.dataOut, m_data);
        chk("validOut", bus.validOut, m_valid);
        chk("counterOut", bus.counterOut, m_co);
        chk("counterValid", bus.counterValid, m_cv);
    endtask

    // Asserts reset between edges and checks outputs clear before any edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_pop", w_pop, 0);
        chk("rst_dataOut", bus.dataOut, 0);
        chk("rst_validOut", bus.validOut, 0);
        chk("rst_counterOut", bus.counterOut, 0);
        chk("rst_counterValid", bus.counterValid, 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic do_init();
        t_init = 1; cycle();
        t_init = 0;
    endtask

    initial begin
        set_idle();
        reset = 1'b0;
        model_reset();
        do_reset();

        // Bring-up: init then five empty cycles.
        do_init();
        repeat (5) cycle();

        // Round-robin over four full ports.
        for (int i = 0; i < 4; i++) t_data[i] = DW'('h100 + i);
        t_empty = 4'h0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("rr_data", bus.dataOut, 'h100 + (k % 4));
        end

        // Stall for 3 cycles, then resume after P0.
        t_stall = 1;
        repeat (3) cycle();
        t_stall = 0;
        cycle();
        chk("stall_resume", bus.dataOut, 'h101);

        // 33 pops on P2 wrap the counter to 1.
        do_init();
        cycle();
        t_empty = 4'b1011;
        repeat (33) cycle();
        t_empty = 4'hF;
        t_req = 1; t_idx = 3'd2;
        cycle();
        chk("cnt_p2", bus.counterOut, 1);
        chk("cnt_p2_valid", bus.counterValid, 1);
        t_idx = 3'd5;
        cycle();
        chk("cnt_idx5", bus.counterOut, 0);
        chk("cnt_idx5_valid", bus.counterValid, 1);
        t_req = 0;

        // Priority: pointer at P1, P2 and P3 pending, P3 almost full.
        t_empty = 4'b1101; t_data[1] = 12'h111;
        cycle();
        t_empty = 4'b0011; t_afull = 4'b1000;
        t_data[2] = 12'h202; t_data[3] = 12'h303;
        cycle();
`ifdef TRANSFER_EGRESS_PRIORITY_EN
        chk("prio_first", bus.dataOut, 'h303);
`else
        chk("prio_first", bus.dataOut, 'h202);
`endif
        t_afull = 4'h0;

        // Seven pops on P0, re-init, first grant is P0 with cleared count.
        t_empty = 4'b1110; t_data[0] = 12'h0A0;
        repeat (7) cycle();
        do_init();
        t_empty = 4'h0;
        cycle();
        t_req = 1; t_idx = 3'd0;
        cycle();
        chk("init_first_grant", bus.dataOut, 'h0A0);
        chk("init_p0_count", bus.counterOut, 0);
        t_req = 0;

        // Asynchronous reset while streaming.
        repeat (2) cycle();
        do_reset();

        // Randomized traffic.
        set_idle();
        do_init();
        for (int n = 0; n < 3000; n++) begin
            t_empty = 4'($urandom) & 4'($urandom);
            t_afull = 4'($urandom);
            t_stall = ($urandom_range(0, 4) == 0);
            t_req   = 1'($urandom);
            t_idx   = 3'($urandom_range(0, 7));
            t_init  = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < 4; i++) t_data[i] = DW'($urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
